// File: rtl/key_input_pkg.sv
// Shared constants for the key-pad front end: register window offsets and counter sizing.
package key_input_pkg;

  localparam int MAX_KEYS = 16;

  localparam logic [23:0] OFS_STATE_L = 24'd0;
  localparam logic [23:0] OFS_STATE_H = 24'd1;
  localparam logic [23:0] OFS_PRESS_L = 24'd2;
  localparam logic [23:0] OFS_PRESS_H = 24'd3;
  localparam logic [23:0] OFS_REL_L   = 24'd4;
  localparam logic [23:0] OFS_REL_H   = 24'd5;

  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: two-flop synchroniser, clk_ce-paced debounce counter and committed level,
// plus one-interval rise/fall markers for the commit that just happened.
module key_debouncer
  import key_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_ce,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;
  logic          synced;

  assign synced = sync_ff[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[0], raw};
  end

  // rise/fall hold for the whole ce interval following the commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else if (clk_ce) begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
        rise   <= synced;
        fall   <= ~synced;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_input_debounced.sv
// Key-pad front end: per-key debouncers, press/release IRQ enables on the CPU bus,
// IRQ pulse register and the active-low state read window at BASE_ADDR.
module key_input_debounced
  import key_input_pkg::*;
#(
  parameter int          NUM_KEYS       = 9,
  parameter int          DEBOUNCE_TICKS = 4,
  parameter logic [23:0] BASE_ADDR      = 24'h2052
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_ce,
  input  logic [NUM_KEYS-1:0] keys_active,
  input  logic [23:0]         bus_address_in,
  input  logic [7:0]          bus_data_in,
  input  logic                bus_write,
  output logic [7:0]          bus_data_out,
  output logic [NUM_KEYS-1:0] key_irqs
);

  localparam logic [MAX_KEYS-1:0] KEY_MASK = MAX_KEYS'((32'h1 << NUM_KEYS) - 1);

  logic [NUM_KEYS-1:0] stable_vec;
  logic [NUM_KEYS-1:0] rise_vec;
  logic [NUM_KEYS-1:0] fall_vec;
  logic [MAX_KEYS-1:0] stable_ext;
  logic [MAX_KEYS-1:0] state_rd;
  logic [MAX_KEYS-1:0] press_en;
  logic [MAX_KEYS-1:0] rel_en;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .clk_ce (clk_ce),
      .raw    (keys_active[i]),
      .stable (stable_vec[i]),
      .rise   (rise_vec[i]),
      .fall   (fall_vec[i])
    );
  end

  function automatic logic hit(input logic [23:0] addr, input logic [23:0] ofs);
    return addr == BASE_ADDR + ofs;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_en <= KEY_MASK;
      rel_en   <= '0;
    end else if (bus_write) begin
      if (hit(bus_address_in, OFS_PRESS_L)) press_en[7:0]  <= bus_data_in & KEY_MASK[7:0];
      if (hit(bus_address_in, OFS_PRESS_H)) press_en[15:8] <= bus_data_in & KEY_MASK[15:8];
      if (hit(bus_address_in, OFS_REL_L))   rel_en[7:0]    <= bus_data_in & KEY_MASK[7:0];
      if (hit(bus_address_in, OFS_REL_H))   rel_en[15:8]   <= bus_data_in & KEY_MASK[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       key_irqs <= '0;
    else if (clk_ce) key_irqs <= (rise_vec & press_en[NUM_KEYS-1:0])
                               | (fall_vec & rel_en[NUM_KEYS-1:0]);
  end

  always_comb begin
    stable_ext = '0;
    stable_ext[NUM_KEYS-1:0] = stable_vec;
    state_rd = reset ? '1 : ~stable_ext;
  end

  always_comb begin
    bus_data_out = '0;
    if      (hit(bus_address_in, OFS_STATE_L)) bus_data_out = state_rd[7:0];
    else if (hit(bus_address_in, OFS_STATE_H)) bus_data_out = state_rd[15:8];
    else if (hit(bus_address_in, OFS_PRESS_L)) bus_data_out = press_en[7:0];
    else if (hit(bus_address_in, OFS_PRESS_H)) bus_data_out = press_en[15:8];
    else if (hit(bus_address_in, OFS_REL_L))   bus_data_out = rel_en[7:0];
    else if (hit(bus_address_in, OFS_REL_H))   bus_data_out = rel_en[15:8];
  end

endmodule

// File: tb/tb_key_input_debounced.sv
// Directed bench for key_input_debounced: 9 keys, 4-tick debounce, clk_ce every 4th clk.
module tb_key_input_debounced;
  import key_input_pkg::*;

  localparam logic [23:0] BASE = 24'h2052;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_ce;
  logic [8:0] keys_active;
  logic [23:0] bus_address_in;
  logic [7:0] bus_data_in;
  logic       bus_write;
  logic [7:0] bus_data_out;
  logic [8:0] key_irqs;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int rises [9];
  logic [8:0] prev_irqs = '0;

  key_input_debounced #(
    .NUM_KEYS(9),
    .DEBOUNCE_TICKS(4),
    .BASE_ADDR(BASE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_ce         (clk_ce),
    .keys_active    (keys_active),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_write      (bus_write),
    .bus_data_out   (bus_data_out),
    .key_irqs       (key_irqs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clk cycle; clk_ce is high on every 4th edge. Returns at posedge+1.
  task automatic cyc(output logic was_ce);
    clk_ce = (phase == 3);
    was_ce = clk_ce;
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    for (int i = 0; i < 9; i++)
      if (key_irqs[i] && !prev_irqs[i]) rises[i]++;
    prev_irqs = key_irqs;
  endtask

  task automatic run_ce(input int n);
    int k = 0;
    logic c;
    while (k < n) begin
      cyc(c);
      if (c) k++;
    end
  endtask

  task automatic rd(input logic [23:0] ofs, input logic [7:0] exp, input string tag);
    bus_address_in = BASE + ofs;
    #1;
    check(tag, {8'h00, bus_data_out}, {8'h00, exp});
  endtask

  task automatic wr(input logic [23:0] ofs, input logic [7:0] data);
    logic c;
    bus_address_in = BASE + ofs;
    bus_data_in    = data;
    bus_write      = 1'b1;
    cyc(c);
    bus_write      = 1'b0;
  endtask

  task automatic clear_rises();
    for (int i = 0; i < 9; i++) rises[i] = 0;
  endtask

  initial begin
    int hi_cnt;
    logic c;
    reset = 1'b1; clk_ce = 1'b0; keys_active = '0;
    bus_address_in = '0; bus_data_in = '0; bus_write = 1'b0;
    clear_rises();

    // 1. reset state
    run_ce(1);
    rd(OFS_STATE_L, 8'hFF, "state_l_in_reset");
    reset = 1'b0;
    rd(OFS_STATE_L, 8'hFF, "state_l_idle");
    rd(OFS_STATE_H, 8'hFF, "state_h_idle");
    rd(OFS_PRESS_L, 8'hFF, "press_l_reset");
    rd(OFS_PRESS_H, 8'h01, "press_h_reset");
    rd(OFS_REL_L,   8'h00, "rel_l_reset");
    rd(OFS_REL_H,   8'h00, "rel_h_reset");
    rd(24'd6,       8'h00, "unmapped_read");
    check("irqs_reset", {7'd0, key_irqs}, 16'h0000);

    // 2. key0 press: commit on 4th ce, pulse for one 4-clk interval
    keys_active[0] = 1'b1;
    run_ce(3);
    rd(OFS_STATE_L, 8'hFF, "key0_before_commit");
    run_ce(1);
    rd(OFS_STATE_L, 8'hFE, "key0_committed");
    check("key0_irq_not_yet", {7'd0, key_irqs}, 16'h0000);
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(c);
      if (key_irqs[0]) hi_cnt++;
    end
    check("key0_pulse_width", 16'(hi_cnt), 16'd4);
    check("key0_pulse_count", 16'(rises[0]), 16'd1);
    keys_active[0] = 1'b0;
    run_ce(6);
    rd(OFS_STATE_L, 8'hFF, "key0_released");
    check("key0_no_release_irq", 16'(rises[0]), 16'd1);

    // 3. glitches on key3
    clear_rises();
    keys_active[3] = 1'b1;
    run_ce(3);
    keys_active[3] = 1'b0;
    run_ce(6);
    rd(OFS_STATE_L, 8'hFF, "glitch3_no_commit");
    check("glitch3_no_irq", 16'(rises[3]), 16'd0);
    keys_active[3] = 1'b1; run_ce(3); keys_active[3] = 1'b0; run_ce(2);
    keys_active[3] = 1'b1; run_ce(3); keys_active[3] = 1'b0; run_ce(2);
    keys_active[3] = 1'b1; run_ce(5);
    rd(OFS_STATE_L, 8'hF7, "glitch5_committed");
    keys_active[3] = 1'b0;
    run_ce(8);
    check("glitch_335_one_press", 16'(rises[3]), 16'd1);
    rd(OFS_STATE_L, 8'hFF, "key3_released");

    // 4. release-only IRQ on key0
    wr(OFS_REL_L, 8'h01);
    wr(OFS_PRESS_L, 8'h00);
    rd(OFS_REL_L,   8'h01, "rel_l_readback");
    rd(OFS_PRESS_L, 8'h00, "press_l_readback");
    clear_rises();
    run_ce(1);
    keys_active[0] = 1'b1;
    run_ce(8);
    rd(OFS_STATE_L, 8'hFE, "key0_pressed_t4");
    check("key0_press_masked", 16'(rises[0]), 16'd0);
    keys_active[0] = 1'b0;
    run_ce(8);
    check("key0_release_pulse", 16'(rises[0]), 16'd1);
    check("irqs_idle_t4", {7'd0, key_irqs}, 16'h0000);

    // 5. key8 in the high byte, enable masking, simultaneous edges
    wr(OFS_PRESS_H, 8'hFF);
    rd(OFS_PRESS_H, 8'h01, "press_h_masked");
    wr(OFS_REL_H, 8'hFF);
    rd(OFS_REL_H, 8'h01, "rel_h_masked");
    wr(OFS_REL_H, 8'h00);
    clear_rises();
    run_ce(1);
    keys_active[8] = 1'b1;
    run_ce(8);
    rd(OFS_STATE_H, 8'hFE, "key8_state_h");
    check("key8_irq", 16'(rises[8]), 16'd1);
    wr(OFS_PRESS_L, 8'hFF);
    rd(OFS_PRESS_L, 8'hFF, "press_l_restore");
    run_ce(1);
    keys_active[1] = 1'b1;
    keys_active[2] = 1'b1;
    run_ce(4);
    rd(OFS_STATE_L, 8'hF9, "keys12_committed");
    check("keys12_irq_not_yet", {7'd0, key_irqs}, 16'h0000);
    run_ce(1);
    check("keys12_same_interval", {7'd0, key_irqs}, 16'h0006);

    // 6. async reset while key1 IRQ is high
    reset = 1'b1;
    #1;
    check("irqs_cleared_async", {7'd0, key_irqs}, 16'h0000);
    rd(OFS_STATE_L, 8'hFF, "state_l_during_reset");
    rd(OFS_STATE_H, 8'hFF, "state_h_during_reset");
    wr(OFS_PRESS_L, 8'h00);
    rd(OFS_PRESS_L, 8'hFF, "write_ignored_in_reset");
    run_ce(1);
    reset = 1'b0;
    run_ce(3);
    rd(OFS_STATE_L, 8'hFF, "post_reset_before_commit");
    run_ce(1);
    rd(OFS_STATE_L, 8'hF9, "post_reset_commit_l");
    rd(OFS_STATE_H, 8'hFE, "post_reset_commit_h");
    check("post_reset_irq_not_yet", {7'd0, key_irqs}, 16'h0000);
    run_ce(1);
    check("post_reset_irqs", {7'd0, key_irqs}, 16'h0106);
    run_ce(1);
    check("post_reset_irqs_clear", {7'd0, key_irqs}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
